seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 208 ++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed 4-digit seven-segment scanner. It takes the hundreds, tens
// and units segment patterns plus a sign bit, and drives one shared segment
// bus and four active-low digit anodes. Digits are visited in the order
// sign -> hundreds -> tens -> units, one slot of REFRESH_DIV cycles each.
//
// A shadow (pending) register set holds a newly loaded value until the next
// frame boundary, so a frame never shows a mix of old and new digits. Optional
// leading-zero blanking hides a zero hundreds digit, and a zero tens digit that
// follows it. The first BLANK_CYCLES cycles of every slot turn all anodes off,
// which stops the previous digit from ghosting onto the next one.
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (4..65535)
//   BLANK_CYCLES  anode-off cycles at the start of each slot (< REFRESH_DIV)
//   ZERO_PAT      segment pattern treated as digit "0" for blanking
//   MINUS_PAT     pattern shown on the sign digit for negative values
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous, active-high reset
//   seg_cent    in   hundreds pattern (bit0..6 = a..g, bit7 = dp, 1 = lit)
//   seg_dec     in   tens pattern, same encoding
//   seg_uni     in   units pattern, same encoding
//   sign        in   1 = value negative
//   load        in   single-cycle strobe capturing the four inputs above
//   lzb_en      in   1 = blank leading zeros (sampled every cycle)
//   seg_out     out  shared segment bus, 1 = lit, registered
//   an_out      out  digit anodes, active-low; [3] sign, [2] hundreds,
//                    [1] tens, [0] units; registered
//   pending     out  a loaded value is waiting for the next frame boundary
//   frame_done  out  one-cycle pulse after a frame boundary
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 8,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter logic [7:0]  ZERO_PAT     = 8'h3F,
    parameter logic [7:0]  MINUS_PAT    = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_cent,
    input  logic [7:0] seg_dec,
    input  logic [7:0] seg_uni,
    input  logic       sign,
    input  logic       load,
    input  logic       lzb_en,
    output logic [7:0] seg_out,
    output logic [3:0] an_out,
    output logic       pending,
    output logic       frame_done
);

    // -------------------------------------------------------------------------
    // Local constants and types
    // -------------------------------------------------------------------------
    localparam int unsigned PSC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(REFRESH_DIV - 1);
    localparam logic [PSC_W-1:0] PSC_BLANK = PSC_W'(BLANK_CYCLES);

    // Digit index doubles as the anode bit position.
    typedef enum logic [1:0] {
        DIG_UNI  = 2'd0,
        DIG_TEN  = 2'd1,
        DIG_HUN  = 2'd2,
        DIG_SIGN = 2'd3
    } dig_e;

    // One complete displayable value.
    typedef struct packed {
        logic [7:0] cent;
        logic [7:0] dec;
        logic [7:0] uni;
        logic       sign;
    } frame_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PSC_W-1:0] psc_q,        psc_d;
    dig_e             dig_q,        dig_d;
    frame_t           act_q,        act_d;
    frame_t           pend_q,       pend_d;
    logic             pending_q,    pending_d;
    logic [7:0]       seg_q,        seg_d;
    logic [3:0]       an_q,         an_d;
    logic             frame_done_q, frame_done_d;

    frame_t           in_frame;
    logic             slot_end;
    logic             boundary;
    logic             blank_phase;
    logic             blank_hun;
    logic             blank_ten;

    assign in_frame.cent = seg_cent;
    assign in_frame.dec  = seg_dec;
    assign in_frame.uni  = seg_uni;
    assign in_frame.sign = sign;

    assign slot_end    = (psc_q == PSC_LAST);
    assign boundary    = slot_end && (dig_q == DIG_UNI);
    assign blank_phase = (psc_q < PSC_BLANK);

    // Tens is only a leading zero when the hundreds digit was one as well.
    assign blank_hun = lzb_en && (act_q.cent == ZERO_PAT);
    assign blank_ten = blank_hun && (act_q.dec == ZERO_PAT);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q        <= '0;
            dig_q        <= DIG_SIGN;
            act_q        <= '0;
            pend_q       <= '0;
            pending_q    <= 1'b0;
            seg_q        <= 8'h00;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            psc_q        <= psc_d;
            dig_q        <= dig_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Scan sequencing: prescaler and digit index
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        psc_d = psc_q + PSC_W'(1);
        dig_d = dig_q;

        if (slot_end) begin
            psc_d = '0;
            unique case (dig_q)
                DIG_SIGN: dig_d = DIG_HUN;
                DIG_HUN:  dig_d = DIG_TEN;
                DIG_TEN:  dig_d = DIG_UNI;
                default:  dig_d = DIG_SIGN;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load handshake: pending shadow registers and frame-boundary swap
    // -------------------------------------------------------------------------
    always_comb begin
        act_d        = act_q;
        pend_d       = pend_q;
        pending_d    = pending_q;
        frame_done_d = boundary;

        if (boundary) begin
            // A load landing exactly on the boundary goes straight to the
            // active set; otherwise a waiting value is promoted. Either way
            // nothing is left pending afterwards.
            if (load) begin
                act_d = in_frame;
            end else if (pending_q) begin
                act_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            // Later loads simply overwrite earlier ones: last one wins.
            pend_d    = in_frame;
            pending_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output stage: next segment/anode values from the current slot
    // -------------------------------------------------------------------------
    always_comb begin
        seg_d = 8'h00;
        an_d  = 4'b1111;

        if (!blank_phase) begin
            an_d = ~(4'b0001 << dig_q);
            unique case (dig_q)
                DIG_SIGN: seg_d = act_q.sign ? MINUS_PAT : 8'h00;
                DIG_HUN:  seg_d = blank_hun ? 8'h00 : act_q.cent;
                DIG_TEN:  seg_d = blank_ten ? 8'h00 : act_q.dec;
                default:  seg_d = act_q.uni;
            endcase
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed and randomized stimulus for seg_scan_driver. The reference model
// derives the scan position purely from the number of cycles since reset
// (slot = cycle / REFRESH_DIV, digit = 3 - slot mod 4) and keeps the displayed
// and waiting values as plain variables updated by the load/boundary rules.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int         RD = 8;
    localparam int         BC = 2;
    localparam logic [7:0] ZP = 8'h3F;
    localparam logic [7:0] MP = 8'h40;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] seg_cent = 8'h00;
    logic [7:0] seg_dec  = 8'h00;
    logic [7:0] seg_uni  = 8'h00;
    logic       sign     = 1'b0;
    logic       load     = 1'b0;
    logic       lzb_en   = 1'b0;
    logic [7:0] seg_out;
    logic [3:0] an_out;
    logic       pending;
    logic       frame_done;

    seg_scan_driver #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .ZERO_PAT    (ZP),
        .MINUS_PAT   (MP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_cent  (seg_cent),
        .seg_dec   (seg_dec),
        .seg_uni   (seg_uni),
        .sign      (sign),
        .load      (load),
        .lzb_en    (lzb_en),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .pending   (pending),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_t;
    logic [7:0] a_cent, a_dec, a_uni;
    logic       a_sign;
    logic [7:0] p_cent, p_dec, p_uni;
    logic       p_sign;
    logic       m_pend;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_fd;
    logic [7:0] shown [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] digit_pattern(input int d, input logic lzb);
        logic hun_zero;
        hun_zero = lzb && (a_cent == ZP);
        case (d)
            3:       return a_sign ? MP : 8'h00;
            2:       return hun_zero ? 8'h00 : a_cent;
            1:       return (hun_zero && a_dec == ZP) ? 8'h00 : a_dec;
            default: return a_uni;
        endcase
    endfunction

    task automatic clear_shown();
        for (int i = 0; i < 4; i++) shown[i] = 8'hEE;
    endtask

    task automatic model_reset();
        m_t    = 0;
        a_cent = 8'h00; a_dec = 8'h00; a_uni = 8'h00; a_sign = 1'b0;
        p_cent = 8'h00; p_dec = 8'h00; p_uni = 8'h00; p_sign = 1'b0;
        m_pend = 1'b0;
        clear_shown();
    endtask

    // One clock: predict, advance the model, let the DUT clock, then compare.
    task automatic step();
        int   psc;
        int   dig;
        logic bnd;
        psc = m_t % RD;
        dig = 3 - ((m_t / RD) % 4);
        bnd = (psc == RD - 1) && (dig == 0);

        if (psc < BC) begin
            e_an  = 4'hF;
            e_seg = 8'h00;
        end else begin
            e_an  = 4'hF ^ (4'h1 << dig);
            e_seg = digit_pattern(dig, lzb_en);
        end
        e_fd = bnd;

        if (bnd) begin
            if (load) begin
                a_cent = seg_cent; a_dec = seg_dec; a_uni = seg_uni; a_sign = sign;
            end else if (m_pend) begin
                a_cent = p_cent; a_dec = p_dec; a_uni = p_uni; a_sign = p_sign;
            end
            m_pend = 1'b0;
        end else if (load) begin
            p_cent = seg_cent; p_dec = seg_dec; p_uni = seg_uni; p_sign = sign;
            m_pend = 1'b1;
        end
        m_t++;

        @(posedge clk);
        @(negedge clk);
        check($sformatf("seg@%0d", m_t), 32'(seg_out), 32'(e_seg));
        check($sformatf("an@%0d", m_t), 32'(an_out), 32'(e_an));
        check($sformatf("frame_done@%0d", m_t), 32'(frame_done), 32'(e_fd));
        check($sformatf("pending@%0d", m_t), 32'(pending), 32'(m_pend));

        case (an_out)
            4'b0111: shown[3] = seg_out;
            4'b1011: shown[2] = seg_out;
            4'b1101: shown[1] = seg_out;
            4'b1110: shown[0] = seg_out;
            default: ;
        endcase
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [7:0] c, input logic [7:0] d, input logic [7:0] u,
                           input logic s);
        seg_cent = c; seg_dec = d; seg_uni = u; sign = s;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Step until the model has crossed a frame boundary (bounded by one frame).
    task automatic run_to_boundary();
        logic bnd;
        for (int i = 0; i <= 4 * RD; i++) begin
            bnd = ((m_t % (4 * RD)) == (4 * RD - 1));
            step();
            if (bnd) return;
        end
        total++;
        bad++;
        $error("FAIL boundary_timeout observed=%0d expected=%0d", m_t, 4 * RD - 1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                               input logic [7:0] s1, input logic [7:0] s0);
        check({tag, "_dig3"}, 32'(shown[3]), 32'(s3));
        check({tag, "_dig2"}, 32'(shown[2]), 32'(s2));
        check({tag, "_dig1"}, 32'(shown[1]), 32'(s1));
        check({tag, "_dig0"}, 32'(shown[0]), 32'(s0));
    endtask

    // Assert reset on a negedge, check the asynchronous clear, release.
    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        #1;
        check("rst_seg", 32'(seg_out), 32'h00);
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("c0_an", 32'(an_out), 32'hF);
        check("c0_seg", 32'(seg_out), 32'h00);
    endtask

    function automatic logic [7:0] rand_pat();
        if ($urandom_range(0, 2) == 0) return ZP;
        return 8'($urandom);
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Defaults after reset: blanked, then sign slot, then the scan.
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 2)  check("spec_an_c2", 32'(an_out), 32'hF);
            if (c == 3)  check("spec_an_c3", 32'(an_out), 32'h7);
            if (c == 8)  check("spec_seg_c8", 32'(seg_out), 32'h00);
            if (c == 11) check("spec_an_c11", 32'(an_out), 32'hB);
            if (c == 19) check("spec_an_c19", 32'(an_out), 32'hD);
            if (c == 27) check("spec_an_c27", 32'(an_out), 32'hE);
            if (c == 32) check("spec_fd_c32", 32'(frame_done), 32'h1);
        end

        // Leading zeros blanked, minus sign shown.
        lzb_en = 1'b1;
        do_load(8'h3F, 8'h3F, 8'h06, 1'b1);
        check("lzb_pending", 32'(pending), 32'h1);
        run_to_boundary();
        clear_shown();
        run(4 * RD);
        check_frame("lzb_on", 8'h40, 8'h00, 8'h00, 8'h06);

        // Same data, blanking off.
        lzb_en = 1'b0;
        do_load(8'h3F, 8'h3F, 8'h06, 1'b1);
        run_to_boundary();
        clear_shown();
        run(4 * RD);
        check_frame("lzb_off", 8'h40, 8'h3F, 8'h3F, 8'h06);

        // Zero tens after a nonzero hundreds stays visible.
        lzb_en = 1'b1;
        do_load(8'h06, 8'h3F, 8'h66, 1'b0);
        run_to_boundary();
        clear_shown();
        run(4 * RD);
        check_frame("lzb_mid0", 8'h00, 8'h06, 8'h3F, 8'h66);

        // Two loads mid-frame: current frame untouched, last load wins.
        run(10);
        clear_shown();
        do_load(8'h06, 8'h3F, 8'h5B, 1'b0);
        run(3);
        do_load(8'h06, 8'h3F, 8'h4F, 1'b0);
        check("dbl_pending", 32'(pending), 32'h1);
        run_to_boundary();
        check("no_tear_units", 32'(shown[0]), 32'h66);
        clear_shown();
        run(4 * RD);
        check_frame("dbl_load", 8'h00, 8'h06, 8'h3F, 8'h4F);

        // Load exactly on the boundary cycle.
        for (int i = 0; i < 4 * RD && (m_t % (4 * RD)) != 4 * RD - 1; i++) step();
        do_load(8'h3F, 8'h06, 8'h5B, 1'b1);
        check("bnd_pending", 32'(pending), 32'h0);
        clear_shown();
        run(4 * RD);
        check_frame("bnd_load", 8'h40, 8'h00, 8'h06, 8'h5B);

        // Reset mid-slot with a value waiting.
        run(11);
        do_load(8'h6D, 8'h7D, 8'h07, 1'b1);
        check("pre_rst_pending", 32'(pending), 32'h1);
        run(2);
        do_reset();
        clear_shown();
        run(5 * RD);
        check_frame("post_rst", 8'h00, 8'h00, 8'h00, 8'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) lzb_en = ~lzb_en;
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                do_load(rand_pat(), rand_pat(), rand_pat(), 1'($urandom_range(0, 1)));
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
